nano_riscv_core: RTL and testbench

Single-cycle RV32I integer core with internal instruction ROM and word-addressed data RAM. Every rising clock edge executes one instruction.
Exposes the current PC, the current instruction word and a debug bus carrying the current instruction's result, for bring-up benches.
Top-level CPU block of the nano-riscv design. Benches drive it from a free-running clock generator with period 2 time units.

---
 rtl/nano_riscv_core.sv | 171 +++++++++++++++++
 tb/tb_nano_riscv_core.sv | 109 ++++++++++
 2 files changed

// File: rtl/nano_riscv_core.sv
// nano_riscv_core: single-cycle RV32I integer core.
// Instruction ROM and word-addressed data RAM are internal. One instruction
// retires on every rising clock edge. o_pc, o_inst and debug expose the
// instruction currently being executed.
`timescale 1ns/1ps
module nano_riscv_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter string       IMEM_INIT  = "imem.hex"
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] debug
);
    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] rom_mem [IMEM_DEPTH];
    logic [31:0] dmem_q  [DMEM_DEPTH];
    logic [31:0] rf_q    [32];
    logic [31:0] pc_q, pc_d;

    // ROM image: unloaded words default to NOP (addi x0,x0,0).
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) rom_mem[i] = 32'h0000_0013;
    end

    // Fetch: pc[1:0] ignored, word address wraps modulo ROM depth.
    logic [31:0] iaddr;
    logic [31:0] inst;
    assign iaddr = {2'b00, pc_q[31:2]} % 32'(IMEM_DEPTH);
    assign inst  = rom_mem[iaddr[IAW-1:0]];

    // Instruction fields and immediates.
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign f7     = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Register reads: x0 is hard-wired to zero.
    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    // Data memory access: same adder serves load and store addressing.
    logic [31:0] eff_addr, daddr, load_data;
    assign eff_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign daddr     = {2'b00, eff_addr[31:2]} % 32'(DMEM_DEPTH);
    assign load_data = dmem_q[daddr[DAW-1:0]];

    logic [31:0] pc_plus4, jal_target, jalr_target, br_target;
    assign pc_plus4    = pc_q + 32'd4;
    assign jal_target  = pc_q + imm_j;
    assign jalr_target = (rs1_val + imm_i) & ~32'd1;
    assign br_target   = pc_q + imm_b;

    // Shared ALU for register-register and register-immediate forms.
    function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (fn)
            3'd0:    alu = alt ? (a - b) : (a + b);
            3'd1:    alu = a << b[4:0];
            3'd2:    alu = {31'd0, $signed(a) < $signed(b)};
            3'd3:    alu = {31'd0, a < b};
            3'd4:    alu = a ^ b;
            3'd5:    alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6:    alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    logic        rd_we, mem_we, br_taken, op_legal, imm_legal;
    logic [31:0] rd_wdata, dbg;

    // Branch condition; funct3 2/3 are not branches.
    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'd0:    br_taken = (rs1_val == rs2_val);
            3'd1:    br_taken = (rs1_val != rs2_val);
            3'd4:    br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    br_taken = (rs1_val <  rs2_val);
            3'd7:    br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // funct7 legality: only add/sub and srl/sra have an alternate form.
    assign op_legal  = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
    assign imm_legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                       (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;

    // Decode/execute: next PC, register write, RAM write and debug value.
    always_comb begin
        pc_d     = pc_plus4;
        rd_we    = 1'b0;
        rd_wdata = 32'd0;
        mem_we   = 1'b0;
        dbg      = 32'd0;
        case (opcode)
            OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; dbg = imm_u; end
            OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; dbg = pc_q + imm_u; end
            OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_d = jal_target; dbg = jal_target; end
            OP_JALR: if (f3 == 3'd0) begin
                rd_we = 1'b1; rd_wdata = pc_plus4; pc_d = jalr_target; dbg = jalr_target;
            end
            OP_BRANCH: if (f3 != 3'd2 && f3 != 3'd3) begin
                if (br_taken) pc_d = br_target;
                dbg = {31'd0, br_taken};
            end
            OP_LOAD: if (f3 == 3'd2) begin
                rd_we = 1'b1; rd_wdata = load_data; dbg = load_data;
            end
            OP_STORE: if (f3 == 3'd2) begin
                mem_we = 1'b1; dbg = eff_addr;
            end
            OP_IMM: if (imm_legal) begin
                rd_we = 1'b1; rd_wdata = alu(f3, (f3 == 3'd5) & f7[5], rs1_val, imm_i); dbg = rd_wdata;
            end
            OP_REG: if (op_legal) begin
                rd_we = 1'b1; rd_wdata = alu(f3, f7[5], rs1_val, rs2_val); dbg = rd_wdata;
            end
            default: ;
        endcase
    end

    // PC register and register file; reset clears x1..x31 and aborts retirement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (rd_we && rd != 5'd0) rf_q[rd] <= rd_wdata;
        end
    end

    // Data RAM write: contents survive reset, writes suppressed while in reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && mem_we) dmem_q[daddr[DAW-1:0]] <= rs2_val;
    end

    assign o_pc   = pc_q;
    assign o_inst = inst;
    assign debug  = dbg;
endmodule

// File: tb/tb_nano_riscv_core.sv
// Directed bench for nano_riscv_core: hand-assembled programs are placed in
// the ROM while the core is held in reset, then each instruction's PC, word
// and debug value are compared against hand-computed expectations.
`timescale 1ns/1ps
module tb_nano_riscv_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst, pc, dbg;
  int          n_cmp = 0;
  int          n_err = 0;

  // Program A: ALU chain, memory, branches, jumps, x0 and illegal word.
  logic [31:0] prog_a [18] = '{
    32'h00500093, 32'hFFD00113, 32'h002081B3, 32'h40110233,  // 00 addi,addi,add,sub
    32'h04000093, 32'h00001137, 32'h23410113, 32'h0020A223,  // 10 addi,lui,addi,sw
    32'h0040A283, 32'h00028313, 32'h00000463, 32'h00100093,  // 20 lw,addi,beq,(skipped)
    32'h00001463, 32'h010000EF, 32'h00700013, 32'h000001B3,  // 30 bne,jal,addi x0,add
    32'hFFFFFFFF, 32'h00008067                               // 40 illegal,jalr
  };
  logic [31:0] a_pc  [18] = '{
    32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
    32'h24, 32'h28, 32'h30, 32'h34, 32'h44, 32'h38, 32'h3C, 32'h40, 32'h44
  };
  logic [31:0] a_dbg [18] = '{
    32'd5, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFF8, 32'h40, 32'h1000, 32'h1234, 32'h44, 32'h1234,
    32'h1234, 32'd1, 32'd0, 32'h44, 32'h38, 32'd7, 32'd0, 32'd0, 32'h38
  };

  // Program B (after mid-run reset): cleared registers, retained RAM, shifts, compares, blt.
  logic [31:0] prog_b [10] = '{
    32'h00008393, 32'h00028393, 32'h00030393, 32'h04402403, 32'hFF000493,
    32'h4024D513, 32'h01C4D593, 32'h00943633, 32'h009426B3, 32'hFC84CEE3
  };
  logic [31:0] b_dbg [10] = '{
    32'd0, 32'd0, 32'd0, 32'h1234, 32'hFFFFFFF0,
    32'hFFFFFFFC, 32'h0000000F, 32'd1, 32'd0, 32'd1
  };

  nano_riscv_core #(.IMEM_INIT("")) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_inst  (inst),
    .o_pc    (pc),
    .debug   (dbg)
  );

  // Clock: period 2.
  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the current instruction's view, then let it retire.
  task automatic step(input string tag, input logic [31:0] exp_pc,
                      input logic [31:0] exp_inst, input logic [31:0] exp_dbg);
    check({tag, ".pc"},    pc,   exp_pc);
    check({tag, ".inst"},  inst, exp_inst);
    check({tag, ".debug"}, dbg,  exp_dbg);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    #0.2;
    for (int i = 0; i < 256; i++) dut.rom_mem[i] = 32'h0000_0013;
    for (int i = 0; i < 18; i++)  dut.rom_mem[i] = prog_a[i];

    // Reset state is visible combinationally.
    @(negedge clk);
    check("rst.pc",    pc,   32'h0);
    check("rst.inst",  inst, 32'h00500093);
    check("rst.debug", dbg,  32'd5);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold.pc", pc, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      step($sformatf("a%0d", i), a_pc[i], prog_a[a_pc[i] >> 2], a_dbg[i]);

    // Mid-run asynchronous reset: PC must drop before any clock edge.
    check("pre_rst.pc", pc, 32'h38);
    rst_n = 1'b0;
    #0.5;
    check("async_rst.pc",   pc,   32'h0);
    check("async_rst.inst", inst, 32'h00500093);
    for (int i = 0; i < 256; i++) dut.rom_mem[i] = 32'h0000_0013;
    for (int i = 0; i < 10; i++)  dut.rom_mem[i] = prog_b[i];
    @(negedge clk);
    check("rst2_hold.pc", pc, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      step($sformatf("b%0d", i), 32'(i * 4), prog_b[i], b_dbg[i]);

    // blt at 0x24 is taken back to 0; x1 is still cleared.
    check("b_loop.pc",    pc,  32'h0);
    check("b_loop.debug", dbg, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
